// File: rtl/easy_traffic_checker.sv
// easy_traffic_checker: AXI-Stream sink that checks an incrementing or
// PRBS31 stream, self-synchronises, tracks lock and counts beats/errors.
module easy_traffic_checker #(
  parameter int DWIDTH     = 32,
  parameter int PATTERN    = 0,
  parameter int CNT_WIDTH  = 48,
  parameter int LOCK_CNT   = 4,
  parameter int UNLOCK_ERR = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DWIDTH-1:0]    s_axis_tdata,
  input  logic                 s_axis_tvalid,
  output logic                 s_axis_tready,
  input  logic                 enable,
  input  logic                 clear,
  output logic                 locked,
  output logic                 err_pulse,
  output logic [CNT_WIDTH-1:0] beat_cnt,
  output logic [CNT_WIDTH-1:0] err_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    HUNT,
    ACQUIRE,
    LOCKED
  } state_t;

  localparam int MW = $clog2(LOCK_CNT + 1);
  localparam int EW = $clog2(UNLOCK_ERR + 1);
  localparam logic [CNT_WIDTH-1:0] CMAX = '1;

  state_t            state;
  logic [DWIDTH-1:0] exp_word;
  logic [MW-1:0]     mcnt;
  logic [EW-1:0]     ecnt;

  logic              beat;
  logic              live;
  logic              match;
  logic              err_inc;
  logic [MW-1:0]     mcnt_inc;
  logic [EW-1:0]     ecnt_inc;
  logic [DWIDTH-1:0] next_data;
  logic [DWIDTH-1:0] next_exp;

  assign beat     = s_axis_tvalid & s_axis_tready;
  assign live     = beat & enable;
  assign match    = (s_axis_tdata == exp_word);
  assign err_inc  = live & (state == LOCKED) & ~match;
  assign mcnt_inc = mcnt + MW'(1);
  assign ecnt_inc = ecnt + EW'(1);

  generate
    if (PATTERN == 1) begin : g_prbs
      // Word bits follow the previous word in the serial sequence, so
      // each new bit taps bits 31 and 28 positions back.
      function automatic logic [DWIDTH-1:0] nxt(
        input logic [DWIDTH-1:0] w
      );
        logic [2*DWIDTH-1:0] s;
        s = {{DWIDTH{1'b0}}, w};
        for (int i = 0; i < DWIDTH; i++) begin
          s[DWIDTH+i] = s[DWIDTH+i-31] ^ s[DWIDTH+i-28];
        end
        return s[2*DWIDTH-1:DWIDTH];
      endfunction
      assign next_data = nxt(s_axis_tdata);
      assign next_exp  = nxt(exp_word);
    end else begin : g_inc
      assign next_data = s_axis_tdata + DWIDTH'(1);
      assign next_exp  = exp_word + DWIDTH'(1);
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      exp_word      <= '0;
      mcnt          <= '0;
      ecnt          <= '0;
      s_axis_tready <= 1'b0;
      locked        <= 1'b0;
      err_pulse     <= 1'b0;
    end else begin
      s_axis_tready <= 1'b1;
      err_pulse     <= err_inc;
      if (!enable) begin
        state  <= IDLE;
        locked <= 1'b0;
      end else if (beat) begin
        unique case (state)
          IDLE, HUNT: begin
            exp_word <= next_data;
            mcnt     <= '0;
            state    <= ACQUIRE;
          end
          ACQUIRE: begin
            exp_word <= next_data;
            if (match) begin
              mcnt <= mcnt_inc;
              if (mcnt_inc == MW'(LOCK_CNT)) begin
                state  <= LOCKED;
                locked <= 1'b1;
                ecnt   <= '0;
              end
            end else begin
              mcnt <= '0;
            end
          end
          LOCKED: begin
            // Free-running so a single corrupted word costs one error.
            exp_word <= next_exp;
            if (match) begin
              ecnt <= '0;
            end else begin
              ecnt <= ecnt_inc;
              if (ecnt_inc == EW'(UNLOCK_ERR)) begin
                state  <= HUNT;
                locked <= 1'b0;
              end
            end
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt <= '0;
      err_cnt  <= '0;
    end else if (clear) begin
      beat_cnt <= '0;
      err_cnt  <= '0;
    end else begin
      if (live && beat_cnt != CMAX) begin
        beat_cnt <= beat_cnt + CNT_WIDTH'(1);
      end
      if (err_inc && err_cnt != CMAX) begin
        err_cnt <= err_cnt + CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_easy_traffic_checker.sv
// tb_easy_traffic_checker: scoreboard bench for an incrementing checker
// and a 64-bit PRBS31 checker with 4-bit counters.
module tb_easy_traffic_checker;

  typedef struct packed {
    logic lk;
    logic ep;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic [31:0] i_data = '0;
  logic        i_valid = 1'b0;
  logic        i_en = 1'b0;
  logic        i_clr = 1'b0;
  logic        i_ready;
  logic        i_locked;
  logic        i_pulse;
  logic [47:0] i_beats;
  logic [47:0] i_errs;

  logic [63:0] p_data = '0;
  logic        p_valid = 1'b0;
  logic        p_en = 1'b0;
  logic        p_clr = 1'b0;
  logic        p_ready;
  logic        p_locked;
  logic        p_pulse;
  logic [3:0]  p_beats;
  logic [3:0]  p_errs;

  logic [30:0] lfsr;
  exp_t        iq[$];
  exp_t        pq[$];
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  easy_traffic_checker u_inc (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tdata(i_data), .s_axis_tvalid(i_valid),
    .s_axis_tready(i_ready), .enable(i_en), .clear(i_clr),
    .locked(i_locked), .err_pulse(i_pulse),
    .beat_cnt(i_beats), .err_cnt(i_errs)
  );

  easy_traffic_checker #(
    .DWIDTH(64), .PATTERN(1), .CNT_WIDTH(4)
  ) u_prbs (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tdata(p_data), .s_axis_tvalid(p_valid),
    .s_axis_tready(p_ready), .enable(p_en), .clear(p_clr),
    .locked(p_locked), .err_pulse(p_pulse),
    .beat_cnt(p_beats), .err_cnt(p_errs)
  );

  task automatic gen_word(output logic [63:0] w);
    logic nb;
    for (int i = 0; i < 64; i++) begin
      nb = lfsr[0] ^ lfsr[3];
      w[i] = nb;
      lfsr = {nb, lfsr[30:1]};
    end
  endtask

  task automatic send_i(input logic [31:0] d, input logic lk,
                        input logic ep);
    exp_t e;
    i_data = d;
    i_valid = 1'b1;
    iq.push_back({lk, ep});
    @(posedge clk); #1;
    e = iq.pop_front();
    checks++;
    if (i_locked !== e.lk || i_pulse !== e.ep) begin
      failures++;
      $display("FAIL inc_beat data=%h got locked=%b pulse=%b want locked=%b pulse=%b",
               d, i_locked, i_pulse, e.lk, e.ep);
    end
  endtask

  task automatic send_p(input logic [63:0] d, input logic lk,
                        input logic ep, input logic valid);
    exp_t e;
    p_data = d;
    p_valid = valid;
    pq.push_back({lk, ep});
    @(posedge clk); #1;
    e = pq.pop_front();
    checks++;
    if (p_locked !== e.lk || p_pulse !== e.ep) begin
      failures++;
      $display("FAIL prbs_beat valid=%b got locked=%b pulse=%b want locked=%b pulse=%b",
               valid, p_locked, p_pulse, e.lk, e.ep);
    end
  endtask

  task automatic chk_i(input string name, input logic [47:0] bc,
                       input logic [47:0] ec);
    checks++;
    if (i_beats !== bc || i_errs !== ec) begin
      failures++;
      $display("FAIL %s got beats=%0d errs=%0d want beats=%0d errs=%0d",
               name, i_beats, i_errs, bc, ec);
    end
  endtask

  task automatic chk_p(input string name, input logic [3:0] bc,
                       input logic [3:0] ec);
    checks++;
    if (p_beats !== bc || p_errs !== ec) begin
      failures++;
      $display("FAIL %s got beats=%0d errs=%0d want beats=%0d errs=%0d",
               name, p_beats, p_errs, bc, ec);
    end
  endtask

  task automatic test_reset;
    #1;
    checks++;
    if ({i_ready, i_locked, i_pulse, i_beats, i_errs} !== '0 ||
        {p_ready, p_locked, p_pulse, p_beats, p_errs} !== '0) begin
      failures++;
      $display("FAIL reset_values got inc_ready=%b prbs_ready=%b want 0",
               i_ready, p_ready);
    end
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    #1;
    checks++;
    if (i_ready !== 1'b0) begin
      failures++;
      $display("FAIL ready_before_edge got %b want 0", i_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (i_ready !== 1'b1 || p_ready !== 1'b1) begin
      failures++;
      $display("FAIL ready_after_edge got %b/%b want 1/1",
               i_ready, p_ready);
    end
  endtask

  task automatic test_increment;
    i_en = 1'b1;
    for (int i = 0; i < 100; i++) send_i(32'(i), i >= 4, 1'b0);
    i_valid = 1'b0;
    @(posedge clk); #1;
    chk_i("inc_counts", 48'd100, 48'd0);
  endtask

  task automatic test_corrupt;
    for (int i = 100; i < 200; i++) begin
      if (i == 150) send_i(32'hDEAD, 1'b1, 1'b1);
      else send_i(32'(i), 1'b1, 1'b0);
    end
    i_valid = 1'b0;
    @(posedge clk); #1;
    chk_i("corrupt_counts", 48'd200, 48'd1);
  endtask

  task automatic test_unlock;
    for (int k = 0; k < 8; k++) send_i(32'hF000_0000 + 32'(k), k < 7, 1'b1);
    chk_i("unlock_counts", 48'd208, 48'd9);
    for (int k = 0; k < 10; k++) send_i(32'd300 + 32'(k), k >= 4, 1'b0);
    i_valid = 1'b0;
    @(posedge clk); #1;
    chk_i("relock_counts", 48'd218, 48'd9);
  endtask

  task automatic test_enable;
    i_en = 1'b0;
    send_i(32'd310, 1'b0, 1'b0);
    chk_i("disabled_beat", 48'd218, 48'd9);
    i_en = 1'b1;
    for (int k = 0; k < 5; k++) send_i(32'd311 + 32'(k), k >= 4, 1'b0);
    i_valid = 1'b0;
    @(posedge clk); #1;
    chk_i("enable_relock", 48'd223, 48'd9);
  endtask

  task automatic test_reset_midstream;
    i_data = 32'd999;
    i_valid = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({i_ready, i_locked, i_pulse, i_beats, i_errs} !== '0) begin
      failures++;
      $display("FAIL async_reset got ready=%b locked=%b beats=%0d want 0",
               i_ready, i_locked, i_beats);
    end
    i_valid = 1'b0;
    @(posedge clk); #2 rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (i_ready !== 1'b1) begin
      failures++;
      $display("FAIL ready_after_reset got %b want 1", i_ready);
    end
    for (int k = 0; k < 10; k++) send_i(32'd400 + 32'(k), k >= 4, 1'b0);
    i_valid = 1'b0;
    @(posedge clk); #1;
    chk_i("reset_relock", 48'd10, 48'd0);
  endtask

  task automatic test_prbs;
    logic [63:0] w;
    lfsr = 31'($urandom) | 31'd1;
    p_en = 1'b1;
    for (int k = 0; k < 20; k++) begin
      gen_word(w);
      if (k == 12) w = w ^ 64'h80;
      send_p(w, k >= 4, k == 12, 1'b1);
      if ($urandom_range(0, 2) == 0) send_p(64'h5A5A, k >= 4, 1'b0, 1'b0);
    end
    p_valid = 1'b0;
    @(posedge clk); #1;
    chk_p("prbs_saturate", 4'd15, 4'd1);
  endtask

  task automatic test_clear;
    logic [63:0] w;
    gen_word(w);
    p_clr = 1'b1;
    send_p(w, 1'b1, 1'b0, 1'b1);
    p_clr = 1'b0;
    p_valid = 1'b0;
    chk_p("clear_beat", 4'd0, 4'd0);
    gen_word(w);
    send_p(w, 1'b1, 1'b0, 1'b1);
    p_valid = 1'b0;
    chk_p("after_clear", 4'd1, 4'd0);
  endtask

  initial begin
    test_reset();
    test_increment();
    test_corrupt();
    test_unlock();
    test_enable();
    test_reset_midstream();
    test_prbs();
    test_clear();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/easy_traffic_checker.md
# easy_traffic_checker

AXI-Stream sink that consumes the read side of the traffic engine's FIFOs (`easy_fifo_axis_*` `m_axis_*`) and verifies the received data against a known pattern, either an incrementing counter or PRBS31. It self-synchronises to the incoming stream and tracks lock. It reports beat and error counts, a lock flag and a per-error pulse for the traffic engine's status registers.

## Interface
Parameters:
- `DWIDTH`, 32: stream data width. Must be ≥31 when `PATTERN`=1.
- `PATTERN`, 0: 0 = incrementing counter, 1 = PRBS31 (x^31+x^28+1).
- `CNT_WIDTH`, 48: width of `beat_cnt` and `err_cnt`.
- `LOCK_CNT`, 4: consecutive matching beats required to declare lock (≥1).
- `UNLOCK_ERR`, 8: consecutive mismatching beats in lock that drop lock (≥1).

Ports (one clock; reset is asynchronous and active-low):
- `clk` in 1: clock for all logic.
- `rst_n` in 1: asynchronous active-low reset.
- `s_axis_tdata` in DWIDTH: stream data.
- `s_axis_tvalid` in 1: stream valid.
- `s_axis_tready` out 1: stream ready, registered.
- `enable` in 1: checker enable, level-sensitive.
- `clear` in 1: synchronous counter clear.
- `locked` out 1: checker is in LOCKED.
- `err_pulse` out 1: one-cycle pulse per mismatching beat while locked.
- `beat_cnt` out CNT_WIDTH: accepted beats while enabled.
- `err_cnt` out CNT_WIDTH: mismatching beats while locked.

## Operation
- Beat transfer: `s_axis_tvalid & s_axis_tready` at a rising edge.
- `s_axis_tready` goes high on the first edge after reset release and stays high. The block never backpressures, and it accepts beats even when `enable`=0.
- Pattern function `next(w)`:
  - PATTERN 0: `w+1` mod 2^DWIDTH.
  - PATTERN 1: the serial bit sequence has `s[n]=s[n-31]^s[n-28]`. Word k bit i is `s[k*DWIDTH+i]`. `next(w)` is the DWIDTH bits that follow word `w`, computed from the previous word's bits and the earlier bits of the same word.
- Internal registers:
  - `exp`: expected next word.
  - `mcnt`: match counter, 0..LOCK_CNT.
  - `ecnt`: consecutive-error counter, 0..UNLOCK_ERR.
- States:
  - IDLE: entered when `enable`=0, from any state, on the next edge. Counters hold. The next beat with `enable`=1 moves to HUNT processing on that same beat (see HUNT).
  - HUNT: on a beat, `exp<=next(data)`, `mcnt<=0`, go to ACQUIRE.
  - ACQUIRE: on a beat, compare data with `exp`.
    - Match: `mcnt+1`. When it reaches LOCK_CNT, go to LOCKED with `ecnt<=0`.
    - Mismatch: `mcnt<=0`, stay in ACQUIRE.
    - In both cases `exp<=next(data)` (reseed from received data).
  - LOCKED: on a beat, `exp<=next(exp)` (free-running, so one corrupted word counts once).
    - Match: `ecnt<=0`.
    - Mismatch: `err_cnt+1`, `err_pulse`, `ecnt+1`. When `ecnt` reaches UNLOCK_ERR, go to HUNT with `locked` falling.
- `beat_cnt` increments on every beat while `enable`=1, in any state.
- Counters saturate at all-ones and never wrap.
- `clear`=1 zeroes `beat_cnt` and `err_cnt` on that edge; the beat in that cycle is not counted. State, `exp`, `mcnt` and `ecnt` are unaffected. `clear` takes priority over increments.
- Reset values (asynchronous, while `rst_n`=0):
  - `s_axis_tready`=0, `locked`=0, `err_pulse`=0, `beat_cnt`=0, `err_cnt`=0.
  - State IDLE, `exp`=0, `mcnt`=0, `ecnt`=0.
- Reset mid-stream drops lock immediately. After release the checker re-hunts with no error counted.

## Timing
- All outputs are registered. Effects of a beat at edge t are visible after edge t:
  - `err_pulse` is high for exactly the cycle following a mismatching beat.
  - `locked` rises in the cycle after the LOCK_CNT-th consecutive match beat.
- Minimum beats from HUNT to `locked`: 1 + LOCK_CNT.
- Idle cycles (`tvalid`=0) change nothing. Matching is per beat, not per cycle.
- Back-to-back beats every cycle are supported. `next()` is single-cycle combinational.
- `enable` falling and a beat on the same edge: the beat is ignored (not counted, no compare), and state goes to IDLE.

## Test plan
- Increment pattern, DWIDTH 32, LOCK_CNT 4: send 0,1,2,…,99 continuously → `locked` high after the 5th beat, `beat_cnt`=100, `err_cnt`=0, `err_pulse` never asserted.
- Locked increment stream, corrupt one word (send 0xDEAD in place of 50) → exactly one `err_pulse`, `err_cnt`=1, `locked` stays 1.
- PRBS31, DWIDTH 64, random seed, random `tvalid` gaps → lock after 5 beats. Flip bit 7 of one word → `err_cnt`=1.
- Locked stream, then 8 consecutive garbage beats (UNLOCK_ERR 8) → `err_cnt`=8, `locked` drops after the 8th. The correct stream resumes → relock after 5 beats.
- Counter saturation, CNT_WIDTH 4: send 20 beats → `beat_cnt`=15. Assert `clear` during a beat → next value 0, that beat not counted.
- `rst_n` low mid-stream while locked → all outputs 0 asynchronously. After release, `s_axis_tready` is 1 one edge later, and the checker relocks without counting errors.
